// File: rtl/l2_ctrl_pkg.sv
// Shared encodings for the L2 request sequencer: MESI states, bus and snoop
// opcodes, snoop responses, request source IDs and the sequencer state enum.
package l2_ctrl_pkg;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    localparam logic [1:0] BUS_READ  = 2'd0;
    localparam logic [1:0] BUS_WRITE = 2'd1;
    localparam logic [1:0] BUS_RFO   = 2'd2;
    localparam logic [1:0] BUS_INV   = 2'd3;

    localparam logic [1:0] SNP_READ  = 2'd0;
    localparam logic [1:0] SNP_WRITE = 2'd1;
    localparam logic [1:0] SNP_RFO   = 2'd2;
    localparam logic [1:0] SNP_INV   = 2'd3;

    localparam logic [1:0] SNPRES_NOHIT = 2'b00;
    localparam logic [1:0] SNPRES_HIT   = 2'b01;
    localparam logic [1:0] SNPRES_HITM  = 2'b10;

    localparam logic [1:0] SRC_DATA  = 2'd0;
    localparam logic [1:0] SRC_INSTR = 2'd1;
    localparam logic [1:0] SRC_SNOOP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_DECIDE,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_BUS_REQ,
        ST_BUS_WAIT,
        ST_UPDATE
    } state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/l2_ctrl_sequencer_arb.sv
// Fixed-priority request arbiter (snoop > data > instruction) with a
// starvation counter that lets the instruction port win over a stream of data
// requests once STARVE_MAX data grants have gone by while it was waiting.
module l2_req_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_snp_valid,
    input  logic i_d_valid,
    input  logic i_i_valid,
    output logic o_gnt_snp,
    output logic o_gnt_d,
    output logic o_gnt_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve;
    logic             w_starved;

    assign w_starved = i_i_valid && (r_starve >= CNT_W'(STARVE_MAX));

    // Pick one grant; a starved instruction port only jumps ahead of data, never snoop.
    always_comb begin
        o_gnt_snp = 1'b0;
        o_gnt_d   = 1'b0;
        o_gnt_i   = 1'b0;
        if (i_en) begin
            if (i_snp_valid) begin
                o_gnt_snp = 1'b1;
            end else if (w_starved) begin
                o_gnt_i = 1'b1;
            end else if (i_d_valid) begin
                o_gnt_d = 1'b1;
            end else if (i_i_valid) begin
                o_gnt_i = 1'b1;
            end
        end
    end

    // Count data grants that bypassed a waiting instruction request; any instruction grant clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (o_gnt_i) begin
            r_starve <= '0;
        end else if (o_gnt_d && i_i_valid && (r_starve < CNT_W'(STARVE_MAX))) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l2_ctrl_sequencer.sv
// L2 request sequencer: grants one request at a time, looks it up in the
// tag/state array, optionally writes back a dirty line and fetches or
// invalidates over the bus, then writes the new MESI state and tag.
module l2_ctrl_sequencer
    import l2_ctrl_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int OFFSET_W   = 6,
    parameter  int INDEX_W    = 14,
    parameter  int WAY_W      = 3,
    parameter  int STARVE_MAX = 4,
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_valid,
    output logic               d_ready,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic               snp_valid,
    output logic               snp_ready,
    input  logic [1:0]         snp_op,
    input  logic [ADDR_W-1:0]  snp_addr,
    output logic               snp_res_valid,
    output logic [1:0]         snp_res,
    output logic               tag_lookup,
    output logic [INDEX_W-1:0] tag_index,
    output logic [TAG_W-1:0]   tag_tag,
    input  logic               tag_hit,
    input  logic [WAY_W-1:0]   tag_way,
    input  logic [1:0]         tag_mesi,
    input  logic [WAY_W-1:0]   tag_vic_way,
    input  logic [1:0]         tag_vic_mesi,
    input  logic [TAG_W-1:0]   tag_vic_tag,
    output logic               tag_wr,
    output logic [WAY_W-1:0]   tag_wr_way,
    output logic [1:0]         tag_wr_mesi,
    output logic [TAG_W-1:0]   tag_wr_tag,
    output logic               tag_lru_touch,
    output logic               bus_req,
    input  logic               bus_ready,
    output logic [1:0]         bus_op,
    output logic [ADDR_W-1:0]  bus_addr,
    input  logic               bus_done,
    input  logic [1:0]         bus_snp,
    output logic               done_valid,
    output logic [1:0]         done_src,
    output logic               done_hit,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt,
    output logic [15:0]        evict_cnt
);

    state_t r_state, w_state_nxt;

    logic [1:0]         r_src;
    logic               r_write;
    logic [1:0]         r_snp_op;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_index;
    logic               r_hit;
    logic               r_upd_wr;
    logic [WAY_W-1:0]   r_wr_way;
    logic [1:0]         r_new_mesi;
    logic [1:0]         r_bus_op;
    logic [1:0]         r_fetch_op;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [15:0]        r_hit_cnt, r_miss_cnt, r_evict_cnt;

    logic              w_gnt_snp, w_gnt_d, w_gnt_i, w_any_gnt, w_arb_en;
    logic [ADDR_W-1:0] w_req_addr;
    logic [ADDR_W-1:0] w_req_line;
    logic [ADDR_W-1:0] w_vic_line;
    logic              w_is_snoop;
    logic              w_line_hit;
    logic              w_decide;
    logic              w_unused;

    // Offset bits never matter: every bus transfer and array access is line-wide.
    assign w_unused = ^{d_addr[OFFSET_W-1:0], i_addr[OFFSET_W-1:0], snp_addr[OFFSET_W-1:0]};

    assign w_arb_en   = (r_state == ST_IDLE) && !reset;
    assign w_any_gnt  = w_gnt_snp || w_gnt_d || w_gnt_i;
    assign w_req_addr = w_gnt_snp ? snp_addr : (w_gnt_d ? d_addr : i_addr);
    assign w_req_line = {r_tag, r_index, {OFFSET_W{1'b0}}};
    assign w_vic_line = {tag_vic_tag, r_index, {OFFSET_W{1'b0}}};
    assign w_is_snoop = (r_src == SRC_SNOOP);
    assign w_line_hit = tag_hit && (tag_mesi != MESI_I);
    assign w_decide   = (r_state == ST_DECIDE);

    l2_req_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_arb_en),
        .i_snp_valid (snp_valid),
        .i_d_valid   (d_valid),
        .i_i_valid   (i_valid),
        .o_gnt_snp   (w_gnt_snp),
        .o_gnt_d     (w_gnt_d),
        .o_gnt_i     (w_gnt_i)
    );

    assign snp_ready = w_gnt_snp;
    assign d_ready   = w_gnt_d;
    assign i_ready   = w_gnt_i;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; bus_done is only honoured in the *_WAIT states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_gnt) w_state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                w_state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (w_is_snoop) begin
                    if (w_line_hit && (tag_mesi == MESI_M) && (r_snp_op != SNP_WRITE))
                        w_state_nxt = ST_WB_REQ;
                    else
                        w_state_nxt = ST_UPDATE;
                end else if (w_line_hit) begin
                    if (r_write && (tag_mesi == MESI_S))
                        w_state_nxt = ST_BUS_REQ;
                    else
                        w_state_nxt = ST_UPDATE;
                end else if (tag_vic_mesi == MESI_M) begin
                    w_state_nxt = ST_WB_REQ;
                end else begin
                    w_state_nxt = ST_BUS_REQ;
                end
            end
            ST_WB_REQ: begin
                if (bus_ready) w_state_nxt = ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
                if (bus_done) w_state_nxt = w_is_snoop ? ST_UPDATE : ST_BUS_REQ;
            end
            ST_BUS_REQ: begin
                if (bus_ready) w_state_nxt = ST_BUS_WAIT;
            end
            ST_BUS_WAIT: begin
                if (bus_done) w_state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, lookup decision, bus operation setup and fill-state capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src      <= SRC_DATA;
            r_write    <= 1'b0;
            r_snp_op   <= SNP_READ;
            r_tag      <= '0;
            r_index    <= '0;
            r_hit      <= 1'b0;
            r_upd_wr   <= 1'b0;
            r_wr_way   <= '0;
            r_new_mesi <= MESI_I;
            r_bus_op   <= BUS_READ;
            r_fetch_op <= BUS_READ;
            r_bus_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_gnt) begin
                        r_src    <= w_gnt_snp ? SRC_SNOOP : (w_gnt_d ? SRC_DATA : SRC_INSTR);
                        r_write  <= w_gnt_d && d_write;
                        r_snp_op <= snp_op;
                        r_tag    <= w_req_addr[ADDR_W-1 -: TAG_W];
                        r_index  <= w_req_addr[OFFSET_W +: INDEX_W];
                    end
                end
                ST_DECIDE: begin
                    r_hit <= w_line_hit;
                    if (w_is_snoop) begin
                        // A snoop miss must not touch the array, so the update cycle skips its write.
                        r_upd_wr   <= w_line_hit;
                        r_wr_way   <= tag_way;
                        r_bus_op   <= BUS_WRITE;
                        r_bus_addr <= w_req_line;
                        if (!w_line_hit)
                            r_new_mesi <= MESI_I;
                        else if (r_snp_op == SNP_WRITE)
                            r_new_mesi <= tag_mesi;
                        else if (r_snp_op == SNP_READ)
                            r_new_mesi <= MESI_S;
                        else
                            r_new_mesi <= MESI_I;
                    end else if (w_line_hit) begin
                        r_upd_wr   <= 1'b1;
                        r_wr_way   <= tag_way;
                        r_new_mesi <= r_write ? MESI_M : tag_mesi;
                        r_bus_op   <= BUS_INV;
                        r_bus_addr <= w_req_line;
                    end else begin
                        r_upd_wr   <= 1'b1;
                        r_wr_way   <= tag_vic_way;
                        r_fetch_op <= r_write ? BUS_RFO : BUS_READ;
                        if (tag_vic_mesi == MESI_M) begin
                            r_bus_op   <= BUS_WRITE;
                            r_bus_addr <= w_vic_line;
                        end else begin
                            r_bus_op   <= r_write ? BUS_RFO : BUS_READ;
                            r_bus_addr <= w_req_line;
                        end
                    end
                end
                ST_WB_WAIT: begin
                    if (bus_done && !w_is_snoop) begin
                        r_bus_op   <= r_fetch_op;
                        r_bus_addr <= w_req_line;
                    end
                end
                ST_BUS_WAIT: begin
                    if (bus_done) begin
                        if (r_bus_op == BUS_READ)
                            r_new_mesi <= (bus_snp == SNPRES_NOHIT) ? MESI_E : MESI_S;
                        else
                            r_new_mesi <= MESI_M;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Hit/miss/eviction statistics, counted once per L1 request at the decision step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_evict_cnt <= '0;
        end else if (w_decide && !w_is_snoop) begin
            if (w_line_hit) begin
                r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
                if (tag_vic_mesi != MESI_I)
                    r_evict_cnt <= sat_inc(r_evict_cnt);
            end
        end
    end

    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
    assign evict_cnt = r_evict_cnt;

    assign tag_lookup = (r_state == ST_LOOKUP);
    assign tag_index  = r_index;
    assign tag_tag    = r_tag;

    assign snp_res_valid = w_decide && w_is_snoop;
    assign snp_res       = (!snp_res_valid || !w_line_hit) ? SNPRES_NOHIT :
                           ((tag_mesi == MESI_M) ? SNPRES_HITM : SNPRES_HIT);

    assign bus_req  = (r_state == ST_WB_REQ) || (r_state == ST_BUS_REQ);
    assign bus_op   = bus_req ? r_bus_op : 2'b00;
    assign bus_addr = bus_req ? r_bus_addr : '0;

    assign tag_wr        = (r_state == ST_UPDATE) && r_upd_wr;
    assign tag_wr_way    = tag_wr ? r_wr_way : '0;
    assign tag_wr_mesi   = tag_wr ? r_new_mesi : MESI_I;
    assign tag_wr_tag    = tag_wr ? r_tag : '0;
    assign tag_lru_touch = tag_wr && !w_is_snoop;

    assign done_valid = (r_state == ST_UPDATE);
    assign done_src   = done_valid ? r_src : 2'b00;
    assign done_hit   = done_valid && r_hit;

endmodule

// File: tb/tb_l2_ctrl_sequencer.sv
// Directed testbench for l2_ctrl_sequencer: walks each request type through
// the sequencer cycle by cycle with a hand-driven tag array and bus.
module tb_l2_ctrl_sequencer;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 14;
    localparam int WAY_W    = 3;
    localparam int TAG_W    = 12;

    localparam logic [1:0] M_I = 2'b00, M_S = 2'b01, M_E = 2'b10, M_M = 2'b11;
    localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RFO = 2'd2;
    localparam logic [1:0] R_NOHIT = 2'b00, R_HIT = 2'b01, R_HITM = 2'b10;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               d_valid = 1'b0, d_write = 1'b0;
    logic [ADDR_W-1:0]  d_addr = '0;
    logic               i_valid = 1'b0;
    logic [ADDR_W-1:0]  i_addr = '0;
    logic               snp_valid = 1'b0;
    logic [1:0]         snp_op = 2'b00;
    logic [ADDR_W-1:0]  snp_addr = '0;
    logic               tag_hit = 1'b0;
    logic [WAY_W-1:0]   tag_way = '0, tag_vic_way = '0;
    logic [1:0]         tag_mesi = 2'b00, tag_vic_mesi = 2'b00;
    logic [TAG_W-1:0]   tag_vic_tag = '0;
    logic               bus_ready = 1'b0, bus_done = 1'b0;
    logic [1:0]         bus_snp = 2'b00;

    logic               d_ready, i_ready, snp_ready, snp_res_valid;
    logic [1:0]         snp_res;
    logic               tag_lookup;
    logic [INDEX_W-1:0] tag_index;
    logic [TAG_W-1:0]   tag_tag;
    logic               tag_wr, tag_lru_touch;
    logic [WAY_W-1:0]   tag_wr_way;
    logic [1:0]         tag_wr_mesi;
    logic [TAG_W-1:0]   tag_wr_tag;
    logic               bus_req;
    logic [1:0]         bus_op;
    logic [ADDR_W-1:0]  bus_addr;
    logic               done_valid, done_hit;
    logic [1:0]         done_src;
    logic [15:0]        hit_cnt, miss_cnt, evict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_ctrl_sequencer #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAY_W(WAY_W), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_ready(d_ready), .d_write(d_write), .d_addr(d_addr),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .snp_res_valid(snp_res_valid), .snp_res(snp_res),
        .tag_lookup(tag_lookup), .tag_index(tag_index), .tag_tag(tag_tag),
        .tag_hit(tag_hit), .tag_way(tag_way), .tag_mesi(tag_mesi),
        .tag_vic_way(tag_vic_way), .tag_vic_mesi(tag_vic_mesi), .tag_vic_tag(tag_vic_tag),
        .tag_wr(tag_wr), .tag_wr_way(tag_wr_way), .tag_wr_mesi(tag_wr_mesi),
        .tag_wr_tag(tag_wr_tag), .tag_lru_touch(tag_lru_touch),
        .bus_req(bus_req), .bus_ready(bus_ready), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_done(bus_done), .bus_snp(bus_snp),
        .done_valid(done_valid), .done_src(done_src), .done_hit(done_hit),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt)
    );

    // Outputs must all be zero while reset is held.
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({d_ready, i_ready, snp_ready, snp_res_valid, tag_lookup, tag_wr, tag_lru_touch, bus_req, done_valid, done_hit} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes got %b want 0", {d_ready, i_ready, snp_ready, snp_res_valid, tag_lookup, tag_wr, tag_lru_touch, bus_req, done_valid, done_hit});
        end
        checks++;
        if ({hit_cnt, miss_cnt, evict_cnt, bus_op, bus_addr, tag_wr_mesi, done_src, tag_index, tag_tag} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values got hit=%0d miss=%0d evict=%0d bus_addr=%h want all 0", hit_cnt, miss_cnt, evict_cnt, bus_addr);
        end
        reset = 1'b0;
    endtask

    // Data read miss, invalid victim, no other sharer -> READ then fill E.
    task automatic test_read_miss();
        tag_hit = 1'b0; tag_way = 3'd0; tag_mesi = M_I;
        tag_vic_way = 3'd2; tag_vic_mesi = M_I; tag_vic_tag = 12'h000;
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h0001_2340;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_ready got %b want 1", d_ready); end
        @(negedge clk);
        checks++;
        if ({d_ready, tag_lookup, tag_index, tag_tag} !== {1'b0, 1'b1, 14'h048D, 12'h000}) begin
            errors++;
            $display("[TB] FAIL rm_lookup got ready=%b lookup=%b idx=%h tag=%h want 0 1 048d 000", d_ready, tag_lookup, tag_index, tag_tag);
        end
        d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({snp_res_valid, tag_lookup, bus_req, tag_wr, done_valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL rm_decide got %b want 00000", {snp_res_valid, tag_lookup, bus_req, tag_wr, done_valid});
        end
        @(negedge clk);
        checks++;
        if ({bus_req, bus_op, bus_addr} !== {1'b1, OP_READ, 32'h0001_2340}) begin
            errors++;
            $display("[TB] FAIL rm_bus_read got req=%b op=%0d addr=%h want 1 0 00012340", bus_req, bus_op, bus_addr);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        checks++;
        if ({bus_req, hit_cnt, miss_cnt, evict_cnt} !== {1'b0, 16'd0, 16'd1, 16'd0}) begin
            errors++;
            $display("[TB] FAIL rm_counts got req=%b hit=%0d miss=%0d evict=%0d want 0 0 1 0", bus_req, hit_cnt, miss_cnt, evict_cnt);
        end
        bus_done = 1'b1; bus_snp = R_NOHIT;
        @(negedge clk);
        bus_done = 1'b0;
        checks++;
        if ({tag_wr, tag_wr_way, tag_wr_mesi, tag_wr_tag, tag_lru_touch} !== {1'b1, 3'd2, M_E, 12'h000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rm_update got wr=%b way=%0d mesi=%b tag=%h touch=%b want 1 2 10 000 1", tag_wr, tag_wr_way, tag_wr_mesi, tag_wr_tag, tag_lru_touch);
        end
        checks++;
        if ({done_valid, done_src, done_hit} !== {1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rm_done got v=%b src=%0d hit=%b want 1 0 0", done_valid, done_src, done_hit);
        end
    endtask

    // Data write hitting an E line -> M with no bus traffic, done in cycle 3.
    task automatic test_write_hit();
        tag_hit = 1'b1; tag_way = 3'd3; tag_mesi = M_E;
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h0001_2340;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin errors++; $display("[TB] FAIL wh_ready got %b want 1", d_ready); end
        @(negedge clk);
        d_valid = 1'b0; d_write = 1'b0;
        @(negedge clk);
        checks++;
        if ({snp_res_valid, done_valid, bus_req} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL wh_decide got %b want 000", {snp_res_valid, done_valid, bus_req});
        end
        @(negedge clk);
        checks++;
        if ({bus_req, tag_wr, tag_wr_way, tag_wr_mesi, tag_lru_touch, done_valid, done_src, done_hit} !== {1'b0, 1'b1, 3'd3, M_M, 1'b1, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wh_update got req=%b wr=%b way=%0d mesi=%b touch=%b done=%b src=%0d hit=%b want 0 1 3 11 1 1 0 1",
                     bus_req, tag_wr, tag_wr_way, tag_wr_mesi, tag_lru_touch, done_valid, done_src, done_hit);
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== {16'd1, 16'd1}) begin
            errors++;
            $display("[TB] FAIL wh_counts got hit=%0d miss=%0d want 1 1", hit_cnt, miss_cnt);
        end
    endtask

    // Snoop RFO to the M line -> HITM, write-back, line goes I; bus_done with bus_ready is ignored.
    task automatic test_snoop_rfo();
        tag_hit = 1'b1; tag_way = 3'd3; tag_mesi = M_M;
        @(negedge clk);
        snp_valid = 1'b1; snp_op = OP_RFO; snp_addr = 32'h0001_2340;
        #1;
        checks++;
        if (snp_ready !== 1'b1) begin errors++; $display("[TB] FAIL sn_ready got %b want 1", snp_ready); end
        @(negedge clk);
        snp_valid = 1'b0;
        checks++;
        if (snp_res_valid !== 1'b0) begin errors++; $display("[TB] FAIL sn_res_early got %b want 0", snp_res_valid); end
        @(negedge clk);
        checks++;
        if ({snp_res_valid, snp_res} !== {1'b1, R_HITM}) begin
            errors++;
            $display("[TB] FAIL sn_res got v=%b res=%b want 1 10", snp_res_valid, snp_res);
        end
        @(negedge clk);
        checks++;
        if ({bus_req, bus_op, bus_addr} !== {1'b1, OP_WRITE, 32'h0001_2340}) begin
            errors++;
            $display("[TB] FAIL sn_wb got req=%b op=%0d addr=%h want 1 1 00012340", bus_req, bus_op, bus_addr);
        end
        bus_ready = 1'b1; bus_done = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0; bus_done = 1'b0;
        checks++;
        if ({bus_req, done_valid, tag_wr} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL sn_accept got %b want 000", {bus_req, done_valid, tag_wr});
        end
        @(negedge clk);
        checks++;
        if ({done_valid, tag_wr} !== 2'b0) begin
            errors++;
            $display("[TB] FAIL sn_early_done got %b want 00", {done_valid, tag_wr});
        end
        bus_done = 1'b1;
        @(negedge clk);
        bus_done = 1'b0;
        checks++;
        if ({tag_wr, tag_wr_way, tag_wr_mesi, tag_lru_touch} !== {1'b1, 3'd3, M_I, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sn_update got wr=%b way=%0d mesi=%b touch=%b want 1 3 00 0", tag_wr, tag_wr_way, tag_wr_mesi, tag_lru_touch);
        end
        checks++;
        if ({done_valid, done_src, hit_cnt, miss_cnt} !== {1'b1, 2'd2, 16'd1, 16'd1}) begin
            errors++;
            $display("[TB] FAIL sn_done got v=%b src=%0d hit=%0d miss=%0d want 1 2 1 1", done_valid, done_src, hit_cnt, miss_cnt);
        end
    endtask

    // Read miss with a dirty LRU victim (tag 0x55) -> WRITE victim line, then READ, fill S.
    task automatic test_dirty_evict();
        tag_hit = 1'b0; tag_mesi = M_I;
        tag_vic_way = 3'd5; tag_vic_mesi = M_M; tag_vic_tag = 12'h055;
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h0001_2340;
        @(negedge clk);
        d_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus_req, bus_op, bus_addr} !== {1'b1, OP_WRITE, 32'h0551_2340}) begin
            errors++;
            $display("[TB] FAIL de_wb got req=%b op=%0d addr=%h want 1 1 05512340", bus_req, bus_op, bus_addr);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_done = 1'b1;
        @(negedge clk);
        bus_done = 1'b0;
        checks++;
        if ({bus_req, bus_op, bus_addr} !== {1'b1, OP_READ, 32'h0001_2340}) begin
            errors++;
            $display("[TB] FAIL de_fetch got req=%b op=%0d addr=%h want 1 0 00012340", bus_req, bus_op, bus_addr);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        bus_done = 1'b1; bus_snp = R_HIT;
        @(negedge clk);
        bus_done = 1'b0; bus_snp = R_NOHIT;
        checks++;
        if ({tag_wr, tag_wr_way, tag_wr_mesi, tag_wr_tag, done_valid, done_hit} !== {1'b1, 3'd5, M_S, 12'h000, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL de_update got wr=%b way=%0d mesi=%b tag=%h done=%b hit=%b want 1 5 01 000 1 0",
                     tag_wr, tag_wr_way, tag_wr_mesi, tag_wr_tag, done_valid, done_hit);
        end
        checks++;
        if ({hit_cnt, miss_cnt, evict_cnt} !== {16'd1, 16'd2, 16'd1}) begin
            errors++;
            $display("[TB] FAIL de_counts got hit=%0d miss=%0d evict=%0d want 1 2 1", hit_cnt, miss_cnt, evict_cnt);
        end
    endtask

    // Data and instruction both valid -> four data grants, then instruction, then data again.
    task automatic test_starvation();
        logic [1:0] seq [6];
        logic [1:0] want [6];
        int n = 0;
        int cyc = 0;
        want = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        for (int k = 0; k < 6; k++) seq[k] = 2'd3;
        tag_hit = 1'b1; tag_way = 3'd1; tag_mesi = M_E;
        tag_vic_mesi = M_I;
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h0001_2340;
        i_valid = 1'b1; i_addr = 32'h0040_0080;
        while (n < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (d_ready) begin seq[n] = 2'd0; n++; end
            else if (i_ready) begin seq[n] = 2'd1; n++; end
        end
        checks++;
        if (n !== 6) begin errors++; $display("[TB] FAIL st_timeout got %0d grants want 6", n); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (seq[k] !== want[k]) begin
                errors++;
                $display("[TB] FAIL st_grant%0d got %0d want %0d", k, seq[k], want[k]);
            end
        end
        @(negedge clk);
        d_valid = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done_valid, hit_cnt, miss_cnt, evict_cnt} !== {1'b1, 16'd7, 16'd2, 16'd1}) begin
            errors++;
            $display("[TB] FAIL st_counts got done=%b hit=%0d miss=%0d evict=%0d want 1 7 2 1", done_valid, hit_cnt, miss_cnt, evict_cnt);
        end
    endtask

    // Reset during BUS_WAIT abandons the fetch; a stray bus_done is ignored; next request runs normally.
    task automatic test_reset_in_flight();
        tag_hit = 1'b0; tag_mesi = M_I; tag_vic_way = 3'd4; tag_vic_mesi = M_I;
        @(negedge clk);
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h0001_2340;
        @(negedge clk);
        d_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_req, bus_op, bus_addr, tag_wr, done_valid, tag_lookup, d_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL ri_outputs got req=%b op=%0d addr=%h wr=%b done=%b want all 0", bus_req, bus_op, bus_addr, tag_wr, done_valid);
        end
        checks++;
        if ({hit_cnt, miss_cnt, evict_cnt} !== 48'b0) begin
            errors++;
            $display("[TB] FAIL ri_counts got hit=%0d miss=%0d evict=%0d want 0 0 0", hit_cnt, miss_cnt, evict_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_done = 1'b1;
        @(negedge clk);
        bus_done = 1'b0;
        checks++;
        if ({done_valid, tag_wr, bus_req} !== 3'b0) begin
            errors++;
            $display("[TB] FAIL ri_stray_done got %b want 000", {done_valid, tag_wr, bus_req});
        end
        tag_hit = 1'b1; tag_way = 3'd6; tag_mesi = M_S;
        d_valid = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin errors++; $display("[TB] FAIL ri_regrant got %b want 1", d_ready); end
        @(negedge clk);
        d_valid = 1'b0;
        checks++;
        if (tag_lookup !== 1'b1) begin errors++; $display("[TB] FAIL ri_lookup got %b want 1", tag_lookup); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({tag_wr, tag_wr_way, tag_wr_mesi, done_valid, done_hit, hit_cnt} !== {1'b1, 3'd6, M_S, 1'b1, 1'b1, 16'd1}) begin
            errors++;
            $display("[TB] FAIL ri_update got wr=%b way=%0d mesi=%b done=%b hit=%b hitcnt=%0d want 1 6 01 1 1 1",
                     tag_wr, tag_wr_way, tag_wr_mesi, done_valid, done_hit, hit_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_snoop_rfo();
        test_dirty_evict();
        test_starvation();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
